// File: rtl/popcount_seq_pkg.sv
// rtl/popcount_seq_pkg.sv - shared state encoding and sizing helper for m_popcount_seq
package popcount_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/m_count_ones.sv
// rtl/m_count_ones.sv - combinational population count of one INPUT_SIZE-bit word
module m_count_ones #(
  parameter int INPUT_SIZE = 42,
  localparam int OUTPUT_SIZE = $clog2(INPUT_SIZE + 1)
) (
  input  logic [INPUT_SIZE-1:0]  i_data,
  output logic [OUTPUT_SIZE-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      o_count = o_count + OUTPUT_SIZE'(i_data[i]);
    end
  end

endmodule

// File: rtl/m_popcount_seq.sv
// rtl/m_popcount_seq.sv - chunked multi-cycle popcount with valid/ready handshake
// Optional threshold compare (i_threshold/o_over) enabled by POPCOUNT_SEQ_THRESHOLD_EN.
module m_popcount_seq
  import popcount_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 240,
  parameter int CHUNK_WIDTH = 42,
  localparam int NUM_CHUNKS = ceil_div(DATA_WIDTH, CHUNK_WIDTH),
  localparam int SUM_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_abort,
  output logic [SUM_W-1:0]      o_sum,
  output logic                  o_valid,
  input  logic                  i_ready
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
  ,
  input  logic [SUM_W-1:0]      i_threshold,
  output logic                  o_over
`endif
);

  localparam int PAD_W = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CNT_W = $clog2(CHUNK_WIDTH + 1);
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PAD_W-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic [CNT_W-1:0] chunk_cnt;
  logic             last_chunk;

  m_count_ones #(
    .INPUT_SIZE(CHUNK_WIDTH)
  ) u_count_ones (
    .i_data (shreg[CHUNK_WIDTH-1:0]),
    .o_count(chunk_cnt)
  );

  assign acc_nxt    = acc + SUM_W'(chunk_cnt);
  assign last_chunk = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = S_RUN;
      end
      S_RUN:   if (last_chunk) state_nxt = S_DONE;
      S_DONE:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including an accept in IDLE.
    if (i_abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      idx     <= '0;
      acc     <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_abort) begin
        shreg   <= '0;
        idx     <= '0;
        acc     <= '0;
        o_sum   <= '0;
        o_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (i_valid) begin
            shreg <= PAD_W'(i_data);
            acc   <= '0;
            idx   <= '0;
          end
          S_RUN: begin
            acc   <= acc_nxt;
            shreg <= shreg >> CHUNK_WIDTH;
            idx   <= idx + IDX_W'(1);
            if (last_chunk) begin
              o_sum   <= acc_nxt;
              o_valid <= 1'b1;
            end
          end
          S_DONE:  if (i_ready) o_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

`ifdef POPCOUNT_SEQ_THRESHOLD_EN
  logic [SUM_W-1:0] thr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr    <= '0;
      o_over <= 1'b0;
    end else if (i_abort) begin
      thr    <= '0;
      o_over <= 1'b0;
    end else if (state == S_IDLE && i_valid) begin
      thr <= i_threshold;
    end else if (state == S_RUN && last_chunk) begin
      o_over <= (acc_nxt >= thr);
    end
  end
`endif

endmodule

// File: tb/tb_m_popcount_seq.sv
// tb/tb_m_popcount_seq.sv - table-driven scoreboard bench for m_popcount_seq
module tb_m_popcount_seq;

  localparam int DW = 240;
  localparam int CW = 42;
  localparam int NC = 6;
  localparam int SW = 8;

  typedef struct {
    logic [DW-1:0] data;
    int            sum;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          i_abort;
  logic [SW-1:0] o_sum;
  logic          o_valid;
  logic          i_ready;

  logic [41:0]   i_data2;
  logic          i_valid2;
  logic          o_ready2;
  logic [5:0]    o_sum2;
  logic          o_valid2;

`ifdef POPCOUNT_SEQ_THRESHOLD_EN
  logic [SW-1:0] i_threshold;
  logic          o_over;
  logic [5:0]    i_threshold2;
  logic          o_over2;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  m_popcount_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_abort(i_abort),
    .o_sum  (o_sum),
    .o_valid(o_valid),
    .i_ready(i_ready)
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
    ,
    .i_threshold(i_threshold),
    .o_over     (o_over)
`endif
  );

  m_popcount_seq #(.DATA_WIDTH(42), .CHUNK_WIDTH(42)) dut_one (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (i_data2),
    .i_valid(i_valid2),
    .o_ready(o_ready2),
    .i_abort(1'b0),
    .o_sum  (o_sum2),
    .o_valid(o_valid2),
    .i_ready(1'b1)
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
    ,
    .i_threshold(i_threshold2),
    .o_over     (o_over2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int cyc);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_timeout"}, {31'd0, o_valid}, 1);
  endtask

  task automatic run_word(input string name, input logic [DW-1:0] d, input int expsum);
    int cyc;
    int exp;
    @(negedge clk);
    check({name, "_ready_in"}, {31'd0, o_ready}, 1);
    i_data  = d;
    i_valid = 1'b1;
    exp_q.push_back(expsum);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = '0;
    wait_valid(name, cyc);
    check({name, "_latency"}, cyc, NC);
    exp = exp_q.pop_front();
    check({name, "_sum"}, o_sum, exp);
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
    check({name, "_over"}, {31'd0, o_over}, (exp >= int'(i_threshold)) ? 1 : 0);
`endif
    @(posedge clk); #1;
    check({name, "_valid_drop"}, {31'd0, o_valid}, 0);
    check({name, "_ready_back"}, {31'd0, o_ready}, 1);
  endtask

  initial begin
    vec_t          vecs[8];
    logic [255:0]  r;
    int            cyc;
    int            exp;
    bit            seen;

    vecs[0] = '{{DW{1'b1}}, 240};
    vecs[1] = '{{DW{1'b0}}, 0};
    vecs[2] = '{{1'b1, {(DW-1){1'b0}}}, 1};
    vecs[3] = '{{60{4'hA}}, 120};
    vecs[4] = '{{DW{1'b1}} >> 121, 119};
    vecs[5] = '{{{(DW-4){1'b0}}, 4'hF}, 4};
    for (int i = 6; i < 8; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].data = r[DW-1:0];
      vecs[i].sum  = $countones(r[DW-1:0]);
    end

    rst_n    = 1'b0;
    i_data   = '0;
    i_valid  = 1'b0;
    i_abort  = 1'b0;
    i_ready  = 1'b1;
    i_data2  = '0;
    i_valid2 = 1'b0;
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
    i_threshold  = 8'd120;
    i_threshold2 = 6'd0;
`endif
    #12;
    check("rst_ready", {31'd0, o_ready}, 1);
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_sum", o_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].sum);
    end

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    i_ready = 1'b0;
    i_data  = {DW{1'b1}} >> 100;
    i_valid = 1'b1;
    exp_q.push_back(140);
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_valid("bp", cyc);
    exp = exp_q.pop_front();
    check("bp_sum", o_sum, exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_data  = {DW{1'b1}};
      i_valid = 1'b1;
      check("bp_hold_valid", {31'd0, o_valid}, 1);
      check("bp_hold_sum", o_sum, exp);
      check("bp_hold_ready", {31'd0, o_ready}, 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, o_valid}, 0);
    check("bp_release_ready", {31'd0, o_ready}, 1);
    @(posedge clk); #1;
    check("bp_no_accept", {31'd0, o_ready}, 1);

    // Abort during the third RUN cycle.
    @(negedge clk);
    i_data  = {DW{1'b1}};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check("abort_ready", {31'd0, o_ready}, 1);
    check("abort_valid", {31'd0, o_valid}, 0);
    check("abort_sum", o_sum, 0);
`ifdef POPCOUNT_SEQ_THRESHOLD_EN
    check("abort_over", {31'd0, o_over}, 0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_valid", {31'd0, seen}, 0);
    run_word("post_abort", {DW{1'b1}}, 240);

    // Abort in IDLE blocks the accept.
    @(negedge clk);
    i_data  = {DW{1'b1}};
    i_valid = 1'b1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_abort = 1'b0;
    check("idle_abort_ready", {31'd0, o_ready}, 1);

    // Asynchronous reset between clock edges in RUN.
    run_word("pre_reset", {60{4'hA}}, 120);
    @(negedge clk);
    i_data  = {DW{1'b1}};
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("areset_ready", {31'd0, o_ready}, 1);
    check("areset_valid", {31'd0, o_valid}, 0);
    check("areset_sum", o_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word("post_reset", {{(DW-4){1'b0}}, 4'hF}, 4);

    // Single-chunk instance: RUN lasts one cycle.
    @(negedge clk);
    i_data2  = {42{1'b1}};
    i_valid2 = 1'b1;
    @(posedge clk); #1;
    i_valid2 = 1'b0;
    check("one_chunk_busy", {31'd0, o_valid2}, 0);
    @(posedge clk); #1;
    check("one_chunk_valid", {31'd0, o_valid2}, 1);
    check("one_chunk_sum", o_sum2, 42);
    @(posedge clk); #1;
    check("one_chunk_drop", {31'd0, o_valid2}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
